// File: rtl/cache_pkg.sv
// cache_pkg: shared widths, FSM state encoding and slowmem opcodes for dm_cache.
//   WORD          default data/address width
//   S_IDLE/S_MISS controller states
//   READ/WRITE    values driven on the slowmem rnotw line
package cache_pkg;
    localparam int WORD = 16;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MISS = 1'b1;
    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick among eligible requesters, pointer advances past each grant.
//   clk, rst_n   clock, asynchronous active-low reset
//   i_elig       eligible requesters
//   i_en         grant enable (pointer only moves on an enabled grant)
//   o_grant      one-hot grant
//   o_idx        grant index
//   o_valid      some requester is eligible
module rr_arbiter #(
    parameter int NPORTS = 2,
    localparam int PW = NPORTS > 1 ? $clog2(NPORTS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NPORTS-1:0] i_elig,
    input  logic              i_en,
    output logic [NPORTS-1:0] o_grant,
    output logic [PW-1:0]     o_idx,
    output logic              o_valid
);
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_cand;

    // Scan downward so the candidate closest to the pointer is the last, winning, assignment.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        for (int k = NPORTS - 1; k >= 0; k--) begin
            w_cand = PW'((int'(r_ptr) + k) % NPORTS);
            if (i_elig[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = w_cand;
            end
        end
        o_grant = o_valid ? NPORTS'(1) << o_idx : '0;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_ptr <= '0;
        else if (i_en && o_valid) r_ptr <= (o_idx == PW'(NPORTS - 1)) ? '0 : o_idx + PW'(1);
endmodule

// File: rtl/dm_cache.sv
// dm_cache: direct-mapped, write-through, one-word-line cache in front of slowmem.
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_req/i_rnotw/i_addr/i_wdata  per-port requests (port p at [p*W +: W])
//   o_ack/o_rdata              one-cycle completion pulse per port, registered read data
//   i_flush                    invalidate all lines
//   o_mem_* / i_mem_*          slowmem strobe/rnotw/addr/wdata and mfc/rdata
//   o_hits/o_misses            saturating read hit/miss counters
module dm_cache
    import cache_pkg::*;
#(
    parameter int DW     = WORD,
    parameter int AW     = WORD,
    parameter int LINES  = 8,
    parameter int NPORTS = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NPORTS-1:0]    i_req,
    input  logic [NPORTS-1:0]    i_rnotw,
    input  logic [NPORTS*AW-1:0] i_addr,
    input  logic [NPORTS*DW-1:0] i_wdata,
    output logic [NPORTS-1:0]    o_ack,
    output logic [DW-1:0]        o_rdata,
    input  logic                 i_flush,
    output logic                 o_mem_strobe,
    output logic                 o_mem_rnotw,
    output logic [AW-1:0]        o_mem_addr,
    output logic [DW-1:0]        o_mem_wdata,
    input  logic                 i_mem_mfc,
    input  logic [DW-1:0]        i_mem_rdata,
    output logic [15:0]          o_hits,
    output logic [15:0]          o_misses
);
    localparam int IXW = $clog2(LINES);
    localparam int PW  = NPORTS > 1 ? $clog2(NPORTS) : 1;

    logic [0:0]        r_state;
    logic              r_flush_pend;
    logic [PW-1:0]     r_port;
    logic [LINES-1:0]  r_valid;
    logic [AW-IXW-1:0] r_tag [LINES];
    logic [DW-1:0]     r_data [LINES];

    logic [NPORTS-1:0] w_grant;
    logic [PW-1:0]     w_idx;
    logic              w_gv, w_en, w_take, w_rnotw, w_hit, w_flush, w_fill;
    logic [AW-1:0]     w_addr;
    logic [DW-1:0]     w_wdata;
    logic [IXW-1:0]    w_ix, w_fill_ix;

    // A flush raised during a miss is remembered and applied once back in IDLE.
    assign w_flush   = i_flush || r_flush_pend;
    assign w_en      = (r_state == S_IDLE) && !w_flush;
    assign w_take    = w_en && w_gv;
    assign w_ix      = w_addr[IXW-1:0];
    assign w_hit     = r_valid[w_ix] && (r_tag[w_ix] == w_addr[AW-1:IXW]);
    assign w_fill    = (r_state == S_MISS) && i_mem_mfc;
    // The miss address stays on o_mem_addr for the whole miss, so it names the line to fill.
    assign w_fill_ix = o_mem_addr[IXW-1:0];

    rr_arbiter #(.NPORTS(NPORTS)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_elig  (i_req & ~o_ack),
        .i_en    (w_en),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_valid (w_gv)
    );

    always_comb begin
        w_addr  = '0;
        w_wdata = '0;
        w_rnotw = READ;
        for (int p = 0; p < NPORTS; p++)
            if (w_idx == PW'(p)) begin
                w_addr  = i_addr[p*AW +: AW];
                w_wdata = i_wdata[p*DW +: DW];
                w_rnotw = i_rnotw[p];
            end
    end

    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[w_fill_ix]  <= o_mem_addr[AW-1:IXW];
            r_data[w_fill_ix] <= i_mem_rdata;
        end else if (w_take && !w_rnotw && w_hit) begin
            r_data[w_ix] <= w_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_flush_pend <= 1'b0;
            r_port       <= '0;
            r_valid      <= '0;
            o_ack        <= '0;
            o_rdata      <= '0;
            o_mem_strobe <= 1'b0;
            o_mem_rnotw  <= READ;
            o_mem_addr   <= '0;
            o_mem_wdata  <= '0;
            o_hits       <= '0;
            o_misses     <= '0;
        end else begin
            o_ack        <= '0;
            o_mem_strobe <= 1'b0;
            if (r_state == S_MISS) begin
                if (i_flush) r_flush_pend <= 1'b1;
                if (i_mem_mfc) begin
                    r_valid[w_fill_ix] <= 1'b1;
                    o_rdata            <= i_mem_rdata;
                    o_ack              <= NPORTS'(1) << r_port;
                    r_state            <= S_IDLE;
                end
            end else if (w_flush) begin
                r_valid      <= '0;
                r_flush_pend <= 1'b0;
            end else if (w_gv) begin
                if (w_rnotw && w_hit) begin
                    o_ack   <= w_grant;
                    o_rdata <= r_data[w_ix];
                    o_hits  <= o_hits + {15'd0, ~&o_hits};
                end else begin
                    o_mem_strobe <= 1'b1;
                    o_mem_rnotw  <= w_rnotw ? READ : WRITE;
                    o_mem_addr   <= w_addr;
                    if (w_rnotw) begin
                        o_misses <= o_misses + {15'd0, ~&o_misses};
                        r_port   <= w_idx;
                        r_state  <= S_MISS;
                    end else begin
                        o_mem_wdata <= w_wdata;
                        o_ack       <= w_grant;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_dm_cache.sv
// tb_dm_cache: directed self-checking bench for dm_cache with a behavioural slowmem.
module tb_dm_cache;
    localparam int MEMDELAY = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = '0, rnotw = '0, ack;
    logic [31:0] addr = '0, wdata = '0;
    logic [15:0] rdata, mem_addr, mem_wdata, hits, misses;
    logic [15:0] mem_rdata = '0;
    logic        flush = 1'b0, mem_strobe, mem_rnotw, mem_mfc = 1'b0;

    int n_cmp = 0, n_err = 0;
    int lat, nstb, got, t0, t1, both, cnt = 0;
    logic        s_rnotw;
    logic [15:0] s_addr, s_wdata, rd, r0, r1, pend_a;
    logic [15:0] mem [256];

    dm_cache #(.DW(16), .AW(16), .LINES(8), .NPORTS(2)) dut (
        .clk(clk), .rst_n(rst_n), .i_req(req), .i_rnotw(rnotw), .i_addr(addr), .i_wdata(wdata),
        .o_ack(ack), .o_rdata(rdata), .i_flush(flush),
        .o_mem_strobe(mem_strobe), .o_mem_rnotw(mem_rnotw), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_mfc(mem_mfc), .i_mem_rdata(mem_rdata),
        .o_hits(hits), .o_misses(misses)
    );

    always #5 clk = ~clk;

    // slowmem: mfc pulses MEMDELAY cycles after a read strobe; writes land immediately.
    always @(negedge clk) begin
        mem_mfc = 1'b0;
        if (cnt == 1) begin
            mem_mfc   = 1'b1;
            mem_rdata = mem[pend_a[7:0]];
        end
        if (cnt != 0) cnt--;
        if (mem_strobe && mem_rnotw) begin
            cnt    = MEMDELAY;
            pend_a = mem_addr;
        end
        if (mem_strobe && !mem_rnotw) mem[mem_addr[7:0]] = mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input int p, input logic rw, input logic [15:0] a, input logic [15:0] d,
                          input int fl_at);
        @(negedge clk);
        rnotw[p] = rw;
        addr[p*16 +: 16] = a;
        wdata[p*16 +: 16] = d;
        req[p] = 1'b1;
        lat = 0; nstb = 0; got = 0;
        while (got == 0 && lat < 50) begin
            @(negedge clk);
            lat++;
            flush = (lat == fl_at);
            if (mem_strobe) begin
                nstb++;
                s_rnotw = mem_rnotw;
                s_addr  = mem_addr;
                s_wdata = mem_wdata;
            end
            if (ack[p]) begin
                got = 1;
                rd  = rdata;
            end
        end
        req[p] = 1'b0;
        flush = 1'b0;
        chk("ack_seen", got, 1);
    endtask

    task automatic arb(input logic [15:0] a0, input logic [15:0] a1, input int e0, input int e1,
                       input logic [15:0] d0, input logic [15:0] d1);
        @(negedge clk);
        rnotw = 2'b11;
        addr  = {a1, a0};
        req   = 2'b11;
        t0 = 0; t1 = 0; both = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (ack == 2'b11) both = 1;
            if (ack[0] && t0 == 0) begin t0 = c; r0 = rdata; req[0] = 1'b0; end
            if (ack[1] && t1 == 0) begin t1 = c; r1 = rdata; req[1] = 1'b0; end
        end
        req = '0;
        chk("arb_t0", t0, e0);
        chk("arb_t1", t1, e1);
        chk("arb_both", both, 0);
        chk("arb_d0", r0, d0);
        chk("arb_d1", r1, d1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'(i);
        mem[5]  = 16'h1234;
        mem[3]  = 16'h0303;
        mem[11] = 16'h0B0B;
        mem[7]  = 16'h0777;

        #12;
        chk("rst_ack", ack, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_strobe", mem_strobe, 0);
        chk("rst_rnotw", mem_rnotw, 1);
        chk("rst_maddr", mem_addr, 0);
        chk("rst_mwdata", mem_wdata, 0);
        chk("rst_hits", hits, 0);
        chk("rst_misses", misses, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // cold read then re-read
        do_req(0, 1, 16'h0005, 0, 0);
        chk("cold_lat", lat, 6);
        chk("cold_nstb", nstb, 1);
        chk("cold_rnotw", s_rnotw, 1);
        chk("cold_addr", s_addr, 16'h0005);
        chk("cold_data", rd, 16'h1234);
        chk("cold_misses", misses, 1);
        do_req(0, 1, 16'h0005, 0, 0);
        chk("hit_lat", lat, 1);
        chk("hit_nstb", nstb, 0);
        chk("hit_data", rd, 16'h1234);
        chk("hit_hits", hits, 1);

        // conflict eviction on index 3
        do_req(0, 1, 16'h0003, 0, 0);
        chk("ev1_nstb", nstb, 1);
        do_req(0, 1, 16'h000B, 0, 0);
        chk("ev2_nstb", nstb, 1);
        chk("ev2_data", rd, 16'h0B0B);
        do_req(0, 1, 16'h0003, 0, 0);
        chk("ev3_nstb", nstb, 1);
        chk("ev3_lat", lat, 6);
        chk("ev3_data", rd, 16'h0303);
        chk("ev_misses", misses, 4);
        chk("ev_hits", hits, 1);

        // write hit updates line, write miss does not allocate
        do_req(1, 0, 16'h0005, 16'hBEEF, 0);
        chk("wr_lat", lat, 1);
        chk("wr_nstb", nstb, 1);
        chk("wr_rnotw", s_rnotw, 0);
        chk("wr_addr", s_addr, 16'h0005);
        chk("wr_wdata", s_wdata, 16'hBEEF);
        do_req(0, 1, 16'h0005, 0, 0);
        chk("wrhit_lat", lat, 1);
        chk("wrhit_data", rd, 16'hBEEF);
        chk("wrhit_hits", hits, 2);
        do_req(1, 0, 16'h0020, 16'hAAAA, 0);
        chk("wrmiss_lat", lat, 1);
        do_req(1, 1, 16'h0020, 0, 0);
        chk("wrmiss_rlat", lat, 6);
        chk("wrmiss_data", rd, 16'hAAAA);
        chk("wrmiss_misses", misses, 5);

        // arbitration: rr=0 -> port0 first; then after a port0 grant, port1 first
        arb(16'h0005, 16'h0003, 1, 2, 16'hBEEF, 16'h0303);
        do_req(0, 1, 16'h0005, 0, 0);
        chk("arb_single_lat", lat, 1);
        arb(16'h0005, 16'h0003, 2, 1, 16'hBEEF, 16'h0303);
        chk("arb_hits", hits, 7);

        // flush during a miss
        do_req(0, 1, 16'h0007, 0, 2);
        chk("fl_lat", lat, 6);
        chk("fl_data", rd, 16'h0777);
        do_req(0, 1, 16'h0007, 0, 0);
        chk("fl_relat", lat, 6);
        chk("fl_renstb", nstb, 1);
        do_req(0, 1, 16'h0005, 0, 0);
        chk("fl_other_lat", lat, 6);
        chk("fl_other_data", rd, 16'hBEEF);
        chk("fl_misses", misses, 8);
        chk("fl_hits", hits, 7);

        // reset in the middle of a miss
        @(negedge clk);
        rnotw[0] = 1'b1;
        addr[15:0] = 16'h000A;
        req[0] = 1'b1;
        @(negedge clk);
        chk("rm_strobe", mem_strobe, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        req = '0;
        #1;
        chk("rm_ack", ack, 0);
        chk("rm_rdata", rdata, 0);
        chk("rm_strobe0", mem_strobe, 0);
        chk("rm_rnotw", mem_rnotw, 1);
        chk("rm_maddr", mem_addr, 0);
        chk("rm_hits", hits, 0);
        chk("rm_misses", misses, 0);
        @(negedge clk);
        rst_n = 1'b1;
        got = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ack != 0 || mem_strobe) got++;
        end
        chk("rm_quiet", got, 0);
        do_req(0, 1, 16'h000A, 0, 0);
        chk("rm_relat", lat, 6);
        chk("rm_redata", rd, 16'h000A);
        chk("rm_remisses", misses, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dm_cache.md
Name: dm_cache

Overview:
- Parametrised, direct-mapped, write-through cache sitting between the two-thread stack processor and `slowmem`.
- Serves NPORTS requesters (one per PID by default) with round-robin arbitration.
- Reads that hit return in 1 cycle instead of the `MEMDELAY` round trip. Misses fill a line from `slowmem`.
- Provides a flush input and hit/miss performance counters.

Parameters:
- DW, 16: data word width.
- AW, 16: address width.
- LINES, 8: number of one-word cache lines; must be a power of two, ≥ 2.
- NPORTS, 2: number of requester ports; must be ≥ 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NPORTS  per-port request. Held high until that port's ack.
- rnotw  in  NPORTS  per-port 1 = read, 0 = write.
- addr  in  NPORTS*AW  per-port address. Port p occupies bits [p*AW +: AW].
- wdata  in  NPORTS*DW  per-port write data, packed the same way.
- ack  out  NPORTS  one-cycle completion pulse per port.
- rdata  out  DW  read data; valid only while ack is set for a read.
- flush  in  1  invalidate all lines.
- mem_strobe  out  1  to `slowmem` strobe.
- mem_rnotw  out  1  to `slowmem` rnotw.
- mem_addr  out  AW  to `slowmem` addr.
- mem_wdata  out  DW  to `slowmem` wdata.
- mem_mfc  in  1  from `slowmem` mfc.
- mem_rdata  in  DW  from `slowmem` rdata.
- hits  out  16  saturating read-hit counter.
- misses  out  16  saturating read-miss counter.

Behaviour:
- Reset (asynchronous, active-low):
  - Outputs: ack=0, rdata=0, mem_strobe=0, mem_rnotw=1, mem_addr=0, mem_wdata=0, hits=0, misses=0.
  - Internal: all valid bits cleared, rr pointer=0, state=IDLE.
  - Reset mid-miss aborts the miss. A mem_mfc arriving later in IDLE is ignored.
- Address split: index = addr[log2(LINES)-1:0]; tag = addr[AW-1:log2(LINES)]. Each line holds valid, tag and one DW-bit word.
- Arbitration:
  - Only in IDLE.
  - Eligible ports: req high AND ack not high in this cycle. A port being acked is masked for one cycle.
  - Search starts at rr pointer, ascending with wrap. rr pointer becomes grant+1 (mod NPORTS) on every grant.
- State machine: IDLE, MISS.
- IDLE, granted read hit (valid && tag match):
  - Next edge: ack[g]=1, rdata=line data, hits+1.
  - Stay IDLE.
- IDLE, granted read miss:
  - Next edge: mem_strobe=1, mem_rnotw=1, mem_addr=addr[g], misses+1.
  - Go to MISS.
- IDLE, granted write:
  - Next edge: mem_strobe=1, mem_rnotw=0, mem_addr and mem_wdata from port g, ack[g]=1. If hit, the line data is updated.
  - Write miss does not allocate.
  - Stay IDLE.
- MISS:
  - mem_strobe deasserts after exactly one cycle.
  - Hold until mem_mfc=1. Then: line[index] <= {valid=1, tag, mem_rdata}; rdata=mem_rdata; ack[g]=1.
  - Return to IDLE.
- mem_strobe is a single-cycle pulse per transaction, never held across cycles. Default is 0.
- ack and rdata are registered. ack is high for exactly 1 cycle. rdata holds its last value otherwise.
- Latency (request sampled high in IDLE → ack edge):
  - Read hit: 1 cycle.
  - Write: 1 cycle.
  - Read miss: 1 + MEMDELAY + 1 cycles.
- flush:
  - Sampled only in IDLE. Clears all valid bits at the next edge.
  - Has priority over any grant in the same cycle; that grant is deferred.
  - flush during MISS is deferred until return to IDLE, then applied. The completing fill is therefore invalidated.
- Counters saturate at 16'hFFFF. Writes do not count.
- The requester must keep addr/wdata/rnotw stable while req is high.

Decomposition:
- Package `cache_pkg` holds:
  - default widths (WORD width 16);
  - state encoding (IDLE, MISS);
  - the mem opcode constants READ=1 and WRITE=0 for rnotw.
- One sub-module: `rr_arbiter`.
  - Parameter NPORTS.
  - Inputs: eligible vector, grant enable.
  - Outputs: one-hot grant, grant index.
  - Owns the rr pointer.

Test Plan:
- Cold read, then re-read:
  - Port0 reads 0x0005 with mem[5]=0x1234.
  - Expect one mem_strobe, mem_rnotw=1, mem_addr=0x0005; ack[0] 6 cycles after req; rdata=0x1234; misses=1.
  - Re-read: ack after 1 cycle, no mem_strobe, hits=1.
- Conflict eviction:
  - Read 0x0003, then 0x000B (same index 3, different tag), then 0x0003 again.
  - Expect 3 misses, 0 hits, each re-read strobing memory.
- Write hit / write miss:
  - After caching 0x0005, port1 writes 0xBEEF to 0x0005.
  - Expect mem_strobe with mem_rnotw=0, ack[1] after 1 cycle.
  - A subsequent read of 0x0005 hits and returns 0xBEEF.
  - Write to uncached 0x0020, then read 0x0020: expect a miss.
- Arbitration:
  - Both ports raise read-hit requests in the same cycle with rr=0.
  - Expect ack[0] first, ack[1] on the next eligible cycle, never both in one cycle.
  - Repeat with both ports requesting: port1 is granted first.
- flush during MISS:
  - Assert flush for 1 cycle while in MISS for 0x0007.
  - Expect ack with the correct data.
  - The next read of 0x0007 misses again.
- Reset mid-miss:
  - Drop reset low 2 cycles after the miss strobe.
  - Expect all outputs at reset values immediately, the later mem_mfc ignored (no ack), and a following read of the same address to miss.
